ahbl_slv_mem: RTL and testbench

AHB-Lite slave that terminates a bus segment onto a parametrised on-chip word memory, with programmable wait states, byte/halfword/word lane writes and, optionally, a two-cycle ERROR response for illegal accesses. It sits behind an AHB-Lite decoder/mux, taking a decoded `hsel` and the shared `hready`, and is the generalised successor of the plain slave-side signal bundle: it adds real data-phase sequencing on top of the same signal set.

---
 rtl/ahbl_slv_mem_if.sv | 35 +++
 rtl/ahbl_slv_mem.sv | 171 +++++++++++++++++
 tb/tb_ahbl_slv_mem.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_slv_mem_if.sv
// AHB-Lite slave-side signal bundle for ahbl_slv_mem.
// The master modport is the decoder/mux side; the slave modport is the memory
// slave. Address-phase and data-phase signals share one bundle, as on the bus.
interface ahbl_slv_mem_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   logic          hsel;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [2:0]    hburst;
   logic [3:0]    hprot;
   logic          hmastlock;
   logic          hready;
   logic [DW-1:0] hwdata;
   logic          hreadyout;
   logic [1:0]    hresp;
   logic [DW-1:0] hrdata;

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
             hready, hwdata,
      output hreadyout, hresp, hrdata
   );

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
             hready, hwdata,
      input  hreadyout, hresp, hrdata
   );

endinterface

// File: rtl/ahbl_slv_mem.sv
// AHB-Lite memory slave: DEPTH words of DW bits behind a decoded hsel, with
// WAIT_STATES wait cycles per data phase and byte/halfword/word lane writes.
// Optional feature macro AHBL_SLV_MEM_ERR_EN: out-of-range, misaligned and
// oversize accesses get a two-cycle ERROR response and never touch memory.
// Without it, addresses wrap modulo DEPTH, low bits are aligned down to the
// transfer size and oversize transfers act as full-word transfers.
// Memory contents are not reset.
module ahbl_slv_mem #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic          hclk,
   input  logic          hreset,
   ahbl_slv_mem_if.slave bus
);

   localparam int BW    = DW / 8;
   localparam int LOGBW = $clog2(BW);
   localparam int IDXW  = $clog2(DEPTH);
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [3:0]      wcnt;
   logic            wload;
   logic            take;
   logic            accept;
   logic            bad_acc;
   logic            ready_c;
   logic [1:0]      resp_c;
   logic            mem_we;

   logic [IDXW-1:0] idx_p1;
   logic [BW-1:0]   lane_p1;
   logic            write_p1;

   logic [DW-1:0]   mem [DEPTH];

   // Byte lanes touched by a transfer. Size is clamped to the bus width and the
   // start lane is aligned down to the transfer size, so a misaligned or
   // oversize request still lands on a well-formed lane group.
   function automatic logic [BW-1:0] lane_en(input logic [AW-1:0] a,
                                             input logic [2:0]    sz);
      logic [BW-1:0] m;
      int            nb;
      int            off;
      nb  = (int'(sz) > LOGBW) ? BW : (1 << sz);
      off = 0;
      for (int i = 0; i < LOGBW; i++)
         if (a[i]) off = off | (1 << i);
      off = off & ~(nb - 1);
      for (int i = 0; i < BW; i++)
         m[i] = (i >= off) && (i < off + nb);
      return m;
   endfunction

`ifdef AHBL_SLV_MEM_ERR_EN
   // Illegal when wider than the bus, when any address bit above the memory
   // span is set, or when a low address bit inside the transfer size is set.
   function automatic logic illegal(input logic [AW-1:0] a,
                                    input logic [2:0]    sz);
      logic bad;
      bad = (int'(sz) > LOGBW);
      for (int i = 0; i < AW; i++) begin
         if ((i >= LOGBW + IDXW) && a[i]) bad = 1'b1;
         if ((i < int'(sz)) && a[i])      bad = 1'b1;
      end
      return bad;
   endfunction

   assign bad_acc = illegal(bus.haddr, bus.hsize);
`else
   assign bad_acc = 1'b0;
`endif

   // Informational or ignored inputs; bits above the memory span only matter
   // when range checking is built in.
   logic unused_bits;
   assign unused_bits = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0],
                          bus.haddr};

   assign accept = bus.hsel & bus.hready & bus.htrans[1];

   // State register.
   always_ff @(posedge hclk) begin
      if (hreset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and response. IDLE, DATA and ERR2 are the only states that
   // end with hreadyout high, so they are the only ones that take a new
   // address phase (back-to-back pipelining out of DATA/ERR2).
   always_comb begin
      state_nxt = state;
      ready_c   = 1'b1;
      resp_c    = 2'b00;
      wload     = 1'b0;
      take      = 1'b0;
      case (state)
         S_IDLE, S_DATA, S_ERR2: begin
            ready_c = 1'b1;
            resp_c  = (state == S_ERR2) ? 2'b01 : 2'b00;
            take    = accept;
            if (!accept) begin
               state_nxt = S_IDLE;
            end else if (bad_acc) begin
               state_nxt = S_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_nxt = S_WAIT;
               wload     = 1'b1;
            end else begin
               state_nxt = S_DATA;
            end
         end
         S_WAIT: begin
            ready_c = 1'b0;
            if (wcnt == 4'd0) state_nxt = S_DATA;
         end
         S_ERR1: begin
            ready_c   = 1'b0;
            resp_c    = 2'b01;
            state_nxt = S_ERR2;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Wait-state down-counter: loaded on entry to WAIT, DATA follows at zero.
   always_ff @(posedge hclk) begin
      if (hreset)                                wcnt <= 4'd0;
      else if (wload)                            wcnt <= WS_LOAD;
      else if (state == S_WAIT && wcnt != 4'd0)  wcnt <= wcnt - 4'd1;
   end

   // Address phase -> data phase: capture word index, lane mask and direction.
   always_ff @(posedge hclk) begin
      if (take) begin
         idx_p1   <= bus.haddr[LOGBW +: IDXW];
         lane_p1  <= lane_en(bus.haddr, bus.hsize);
         write_p1 <= bus.hwrite;
      end
   end

   // A reset arriving in the closing cycle of a write data phase drops the write.
   assign mem_we = (state == S_DATA) && write_p1 && !hreset;

   // Memory write: enabled lanes commit on the closing edge of the data phase.
   always_ff @(posedge hclk) begin
      if (mem_we) begin
         for (int i = 0; i < BW; i++)
            if (lane_p1[i]) mem[idx_p1][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
   end

   assign bus.hreadyout = ready_c;
   assign bus.hresp     = resp_c;
   assign bus.hrdata    = (state == S_DATA) ? mem[idx_p1] : '0;

endmodule

// File: tb/tb_ahbl_slv_mem.sv
// Directed bench for ahbl_slv_mem. Three slaves (WAIT_STATES 0, 2, 3) sit
// behind a small decoder/mux model selected by 'sel'; hready is the selected
// slave's hreadyout. Expected values are hand-computed constants.
module tb_ahbl_slv_mem;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic hclk   = 1'b0;
   logic hreset = 1'b1;
   always #5 hclk = ~hclk;

   int vectors     = 0;
   int miscompares = 0;

   int          sel;
   logic        m_hsel;
   logic [31:0] m_haddr;
   logic [1:0]  m_htrans;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [2:0]  m_hburst;
   logic [31:0] m_hwdata;

   logic        hready_mux;
   logic [1:0]  hresp_mux;
   logic [31:0] hrdata_mux;

   ahbl_slv_mem_if #(.AW(32), .DW(32)) if0 ();
   ahbl_slv_mem_if #(.AW(32), .DW(32)) if2 ();
   ahbl_slv_mem_if #(.AW(32), .DW(32)) if3 ();

   ahbl_slv_mem #(.AW(32), .DW(32), .DEPTH(1024), .WAIT_STATES(0))
      u_ws0 (.hclk(hclk), .hreset(hreset), .bus(if0));
   ahbl_slv_mem #(.AW(32), .DW(32), .DEPTH(1024), .WAIT_STATES(2))
      u_ws2 (.hclk(hclk), .hreset(hreset), .bus(if2));
   ahbl_slv_mem #(.AW(32), .DW(32), .DEPTH(1024), .WAIT_STATES(3))
      u_ws3 (.hclk(hclk), .hreset(hreset), .bus(if3));

   assign if0.hsel = m_hsel && (sel == 0);
   assign if2.hsel = m_hsel && (sel == 1);
   assign if3.hsel = m_hsel && (sel == 2);

   assign if0.haddr = m_haddr;   assign if2.haddr = m_haddr;   assign if3.haddr = m_haddr;
   assign if0.htrans = m_htrans; assign if2.htrans = m_htrans; assign if3.htrans = m_htrans;
   assign if0.hwrite = m_hwrite; assign if2.hwrite = m_hwrite; assign if3.hwrite = m_hwrite;
   assign if0.hsize = m_hsize;   assign if2.hsize = m_hsize;   assign if3.hsize = m_hsize;
   assign if0.hburst = m_hburst; assign if2.hburst = m_hburst; assign if3.hburst = m_hburst;
   assign if0.hprot = 4'b0011;   assign if2.hprot = 4'b0011;   assign if3.hprot = 4'b0011;
   assign if0.hmastlock = 1'b0;  assign if2.hmastlock = 1'b0;  assign if3.hmastlock = 1'b0;
   assign if0.hwdata = m_hwdata; assign if2.hwdata = m_hwdata; assign if3.hwdata = m_hwdata;
   assign if0.hready = hready_mux;
   assign if2.hready = hready_mux;
   assign if3.hready = hready_mux;

   always_comb begin
      case (sel)
         0: begin
            hready_mux = if0.hreadyout; hresp_mux = if0.hresp; hrdata_mux = if0.hrdata;
         end
         1: begin
            hready_mux = if2.hreadyout; hresp_mux = if2.hresp; hrdata_mux = if2.hrdata;
         end
         default: begin
            hready_mux = if3.hreadyout; hresp_mux = if3.hresp; hrdata_mux = if3.hrdata;
         end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   // Wait out the current data phase; returns the number of stalled cycles,
   // the response on its first and last cycle and the final read data.
   task automatic data_phase(output int low, output logic [31:0] rd,
                             output logic [1:0] r0, output logic [1:0] rn);
      bit first = 1'b1;
      low = 0;
      r0  = 2'bxx;
      forever begin
         @(negedge hclk);
         if (first) r0 = hresp_mux;
         first = 1'b0;
         if (hready_mux === 1'b1) break;
         low++;
         if (low > 40) begin
            vectors++;
            miscompares++;
            $error("FAIL data_phase_timeout: observed %0d stall cycles, required completion", low);
            break;
         end
         @(posedge hclk);
         #1;
      end
      rd = hrdata_mux;
      rn = hresp_mux;
   endtask

   // Single non-pipelined transfer starting from an idle slave.
   task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output int low, output logic [1:0] r0, output logic [1:0] rn);
      m_hsel   = 1'b1;
      m_htrans = T_NSEQ;
      m_haddr  = a;
      m_hwrite = wr;
      m_hsize  = sz;
      m_hburst = 3'b000;
      step();
      m_htrans = T_IDLE;
      m_hwdata = wd;
      data_phase(low, rd, r0, rn);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          low;
      int          tot;
      logic [31:0] rd;
      logic [1:0]  r0;
      logic [1:0]  rn;

      sel      = 0;
      m_hsel   = 1'b0;
      m_haddr  = '0;
      m_htrans = T_IDLE;
      m_hwrite = 1'b0;
      m_hsize  = 3'd2;
      m_hburst = 3'b000;
      m_hwdata = '0;

      // Reset state
      hreset = 1'b1;
      repeat (3) @(posedge hclk);
      #1;
      hreset = 1'b0;
      @(negedge hclk);
      chk("rst_hreadyout", 32'(hready_mux), 32'd1);
      chk("rst_hresp", 32'(hresp_mux), 32'd0);
      chk("rst_hrdata", hrdata_mux, 32'd0);

      // WAIT_STATES=0: write then read the same word back-to-back
      step();
      m_hsel = 1'b1; m_htrans = T_NSEQ; m_haddr = 32'h10; m_hwrite = 1'b1; m_hsize = 3'd2;
      step();
      m_hwdata = 32'hDEADBEEF; m_hwrite = 1'b0;
      @(negedge hclk);
      chk("b2b_wr_ready", 32'(hready_mux), 32'd1);
      step();
      m_htrans = T_IDLE;
      @(negedge hclk);
      chk("b2b_rd_ready", 32'(hready_mux), 32'd1);
      chk("b2b_rd_data", hrdata_mux, 32'hDEADBEEF);
      chk("b2b_rd_resp", 32'(hresp_mux), 32'd0);
      step();
      @(negedge hclk);
      chk("idle_after_b2b_rdata", hrdata_mux, 32'd0);
      step();

      // Byte lanes
      xfer(32'h20, 1'b1, 3'd2, 32'h11223344, rd, low, r0, rn);
      chk("ws0_word_wr_stall", 32'(low), 32'd0);
      xfer(32'h21, 1'b1, 3'd0, 32'h0000AA00, rd, low, r0, rn);
      xfer(32'h22, 1'b1, 3'd1, 32'hBBCC0000, rd, low, r0, rn);
      xfer(32'h20, 1'b0, 3'd2, 32'h0, rd, low, r0, rn);
      chk("lanes_merge", rd, 32'hBBCCAA44);

      // Illegal access handling
      xfer(32'h0, 1'b1, 3'd2, 32'h01020304, rd, low, r0, rn);
      xfer(32'h30, 1'b1, 3'd2, 32'h55555555, rd, low, r0, rn);
      xfer(32'h3, 1'b0, 3'd1, 32'h0, rd, low, r0, rn);
`ifdef AHBL_SLV_MEM_ERR_EN
      chk("mis_hw_stall", 32'(low), 32'd1);
      chk("mis_hw_resp_first", 32'(r0), 32'd1);
      chk("mis_hw_resp_last", 32'(rn), 32'd1);
      chk("mis_hw_rdata", rd, 32'd0);
`else
      chk("mis_hw_stall", 32'(low), 32'd0);
      chk("mis_hw_resp_first", 32'(r0), 32'd0);
      chk("mis_hw_resp_last", 32'(rn), 32'd0);
      chk("mis_hw_rdata", rd, 32'h01020304);
`endif
      xfer(32'h1030, 1'b1, 3'd2, 32'h99999999, rd, low, r0, rn);
`ifdef AHBL_SLV_MEM_ERR_EN
      chk("oob_wr_stall", 32'(low), 32'd1);
      chk("oob_wr_resp_first", 32'(r0), 32'd1);
      chk("oob_wr_resp_last", 32'(rn), 32'd1);
`else
      chk("oob_wr_stall", 32'(low), 32'd0);
      chk("oob_wr_resp_first", 32'(r0), 32'd0);
      chk("oob_wr_resp_last", 32'(rn), 32'd0);
`endif
      xfer(32'h30, 1'b0, 3'd2, 32'h0, rd, low, r0, rn);
`ifdef AHBL_SLV_MEM_ERR_EN
      chk("oob_target_word", rd, 32'h55555555);
`else
      chk("oob_target_word", rd, 32'h99999999);
`endif

      // WAIT_STATES=3: fill words 0..3, then an INCR4 read burst
      sel = 2;
      for (int k = 0; k < 4; k++) begin
         xfer(32'(4 * k), 1'b1, 3'd2, 32'hC0DE0000 + 32'(k), rd, low, r0, rn);
         if (k == 0) chk("ws3_wr_stall", 32'(low), 32'd3);
      end
      m_hsel = 1'b1; m_htrans = T_NSEQ; m_haddr = 32'h0; m_hwrite = 1'b0;
      m_hsize = 3'd2; m_hburst = 3'b011;
      step();
      tot = 0;
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            m_htrans = T_SEQ;
            m_haddr  = 32'(4 * (k + 1));
         end else begin
            m_htrans = T_IDLE;
         end
         data_phase(low, rd, r0, rn);
         chk($sformatf("incr4_beat%0d_stall", k), 32'(low), 32'd3);
         chk($sformatf("incr4_beat%0d_data", k), rd, 32'hC0DE0000 + 32'(k));
         tot += low + 1;
         step();
      end
      chk("incr4_total_cycles", 32'(tot), 32'd16);

      // BUSY inside an INCR burst, then IDLE with hsel high
      m_htrans = T_NSEQ; m_haddr = 32'h0; m_hburst = 3'b001;
      step();
      m_htrans = T_BUSY; m_haddr = 32'h4;
      data_phase(low, rd, r0, rn);
      chk("busy_beat0_data", rd, 32'hC0DE0000);
      step();
      m_htrans = T_SEQ;
      @(negedge hclk);
      chk("busy_dp_ready", 32'(hready_mux), 32'd1);
      chk("busy_dp_resp", 32'(hresp_mux), 32'd0);
      chk("busy_dp_rdata", hrdata_mux, 32'd0);
      step();
      m_htrans = T_IDLE; m_hwrite = 1'b1; m_haddr = 32'h8; m_hwdata = 32'hFFFFFFFF;
      data_phase(low, rd, r0, rn);
      chk("busy_beat1_stall", 32'(low), 32'd3);
      chk("busy_beat1_data", rd, 32'hC0DE0001);
      step();
      @(negedge hclk);
      chk("idle_sel_ready", 32'(hready_mux), 32'd1);
      chk("idle_sel_rdata", hrdata_mux, 32'd0);
      step();
      m_hwrite = 1'b0;
      xfer(32'h8, 1'b0, 3'd2, 32'h0, rd, low, r0, rn);
      chk("idle_sel_no_write", rd, 32'hC0DE0002);

      // WAIT_STATES=2: reset in the middle of a write
      sel = 1;
      xfer(32'h40, 1'b1, 3'd2, 32'h12345678, rd, low, r0, rn);
      chk("ws2_wr_stall", 32'(low), 32'd2);
      m_hsel = 1'b1; m_htrans = T_NSEQ; m_haddr = 32'h40; m_hwrite = 1'b1; m_hsize = 3'd2;
      step();
      m_htrans = T_IDLE; m_hwdata = 32'hFFFFFFFF;
      @(negedge hclk);
      chk("pre_rst_hreadyout", 32'(hready_mux), 32'd0);
      hreset = 1'b1;
      step();
      @(negedge hclk);
      chk("mid_rst_hreadyout", 32'(hready_mux), 32'd1);
      chk("mid_rst_hresp", 32'(hresp_mux), 32'd0);
      chk("mid_rst_hrdata", hrdata_mux, 32'd0);
      repeat (2) @(posedge hclk);
      #1;
      hreset = 1'b0;
      xfer(32'h40, 1'b0, 3'd2, 32'h0, rd, low, r0, rn);
      chk("rst_write_dropped", rd, 32'h12345678);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
